// File: rtl/iter_comparator_pkg.sv
// Shared types and constants for the iterative slice-serial magnitude comparator.
package iter_comparator_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefSlice = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StCmp  = 1'b1
  } state_e;

  // Result vector ordering is {gt, eq, lt}.
  localparam logic [2:0] ResNone = 3'b000;
  localparam logic [2:0] ResGt   = 3'b100;
  localparam logic [2:0] ResEq   = 3'b010;
  localparam logic [2:0] ResLt   = 3'b001;

endpackage

// File: rtl/iter_comparator_slice_cmp.sv
// Combinational unsigned magnitude compare of one operand slice.
module iter_comparator_slice_cmp #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/iter_comparator.sv
// Compares two operands SLICE bits per cycle, MSB slice first, exiting early on the
// first unequal slice. Signed mode is handled by flipping the operand MSBs at latch time.
module iter_comparator
  import iter_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SLICE = DefSlice
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NS   = WIDTH / SLICE;
  localparam int unsigned IdxW = (NS > 1) ? $clog2(NS) : 1;

  if (SLICE == 0 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
    $fatal(1, "iter_comparator: WIDTH must be a positive multiple of SLICE");
  end

  state_e            r_state, w_state_next;
  logic [IdxW-1:0]   r_idx, w_idx_next;
  logic [WIDTH-1:0]  r_a, w_a_next;
  logic [WIDTH-1:0]  r_b, w_b_next;
  logic [2:0]        r_res, w_res_next;
  logic              r_done, w_done_next;

  logic [SLICE-1:0]  w_slice_a, w_slice_b;
  logic              w_slice_gt, w_slice_eq, w_slice_lt;

  assign w_slice_a = r_a[r_idx*SLICE +: SLICE];
  assign w_slice_b = r_b[r_idx*SLICE +: SLICE];

  iter_comparator_slice_cmp #(
    .SLICE (SLICE)
  ) slice_cmp (
    .i_a  (w_slice_a),
    .i_b  (w_slice_b),
    .o_gt (w_slice_gt),
    .o_eq (w_slice_eq),
    .o_lt (w_slice_lt)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_res_next   = r_res;
    w_done_next  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          // Inverting the MSB maps two's-complement order onto unsigned order.
          w_a_next            = a;
          w_b_next            = b;
          w_a_next[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
          w_b_next[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
          w_idx_next          = IdxW'(NS - 1);
          w_state_next        = StCmp;
        end
      end
      StCmp: begin
        if (en) begin
          if (!w_slice_eq) begin
            w_res_next   = w_slice_gt ? ResGt : (w_slice_lt ? ResLt : ResNone);
            w_done_next  = 1'b1;
            w_state_next = StIdle;
          end else if (r_idx == '0) begin
            w_res_next   = ResEq;
            w_done_next  = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_idx_next   = r_idx - 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= ResNone;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_res   <= w_res_next;
      r_done  <= w_done_next;
    end
  end

  assign busy = (r_state == StCmp);
  assign done = r_done;
  assign gt   = r_res[2];
  assign eq   = r_res[1];
  assign lt   = r_res[0];

endmodule

// File: tb/tb_iter_comparator.sv
// Directed plus randomized bench for iter_comparator against an arithmetic reference model.
module tb_iter_comparator;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         clk;
  logic         rst;
  logic         start;
  logic         en;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int         checks;
  int         failures;
  logic [2:0] last_res;

  iter_comparator #(
    .WIDTH (W),
    .SLICE (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .en          (en),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {gt, eq, lt} straight from the numeric values.
  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sm);
    if (sm) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // Slices examined: down to the slice holding the highest differing bit, else all.
  function automatic int slices_needed(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] diff;
    diff = x ^ y;
    for (int p = W - 1; p >= 0; p--) begin
      if (diff[p]) return NS - p / S;
    end
    return NS;
  endfunction

  // stall: 0 = en always 1, 1 = random en, 2 = en low for the first 3 cycles.
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsm,
                         input int stall, input bit predriven, input bit hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic nsm);
    logic [2:0] exp;
    int         k;
    int         enabled;
    bit         en_now;
    bit         got;
    exp = model_res(ta, tb, tsm);
    k   = slices_needed(ta, tb);
    if (!predriven) begin
      a = ta; b = tb; signed_mode = tsm; start = 1'b1;
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", {30'b0, busy, done}, 32'h2);
    if (hold) begin
      a = na; b = nb; signed_mode = nsm; start = 1'b1;
    end else begin
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom_range(0, 1));
      start = 1'b0;
    end
    enabled = 0;
    got     = 1'b0;
    for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
      case (stall)
        1:       en_now = 1'($urandom_range(0, 1));
        2:       en_now = (cyc > 3);
        default: en_now = 1'b1;
      endcase
      en = en_now;
      if (stall != 0 && !hold) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (en_now) enabled++;
      if (enabled == k) begin
        got = 1'b1;
        check("done_busy", {30'b0, busy, done}, 32'h1);
        check("result", {29'b0, gt, eq, lt}, {29'b0, exp});
        if (!hold) start = 1'b0;
      end else begin
        check("inflight", {30'b0, busy, done}, 32'h2);
      end
    end
    if (!got) check("timeout", 32'h0, 32'h1);
    last_res = exp;
    en       = 1'b1;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_hold", {27'b0, busy, done, gt, eq, lt}, {27'b0, 2'b00, last_res});
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rsm;
    int           mode;
    checks = 0; failures = 0; last_res = 3'b000;
    rst = 1'b1; start = 1'b0; en = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'b0, busy, done, gt, eq, lt}, 32'h0);
    start = 1'b1; en = 1'b1; a = 16'h1111;
    @(posedge clk); #1;
    check("reset_overrides_start", {27'b0, busy, done, gt, eq, lt}, 32'h0);
    start = 1'b0; rst = 1'b0;
    idle_check(1);

    run_cmp(16'h8000, 16'h7FFF, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_check(1);
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_cmp(16'h1234, 16'h1234, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_cmp(16'h1234, 16'h1234, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_cmp(16'h1235, 16'h1234, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_cmp(16'h1234, 16'h1334, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_cmp(16'hFFFF, 16'h0001, 1'b1, 2, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_check(2);

    // Reset in the middle of an equal-operand compare.
    a = 16'hAAAA; b = 16'hAAAA; signed_mode = 1'b0; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_clear", {27'b0, busy, done, gt, eq, lt}, 32'h0);
    rst = 1'b0;
    last_res = 3'b000;
    idle_check(3);
    run_cmp(16'h0001, 16'h0000, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Back-to-back: start held across done.
    run_cmp(16'h1234, 16'h1334, 1'b0, 0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle_check(1);

    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 3));
      ra   = W'($urandom);
      rsm  = 1'($urandom_range(0, 1));
      case (mode)
        1:       rb = ra;
        2:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, rsm, int'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0, 1'b0);
      if (it % 8 == 0) idle_check(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_comparator.md
ITER_COMPARATOR -- requirements
Module: iter_comparator

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a positive multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits compared per cycle; NS = WIDTH/SLICE slices, NS >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a comparison; accepted only when busy=0.
REQ-006 en  input  1  enable; 0 stalls an in-progress comparison.
REQ-007 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-008 a, b  input  WIDTH each  operands; sampled with start.
REQ-009 busy  output  1  comparison in progress.
REQ-010 done  output  1  single-cycle pulse: result valid.
REQ-011 gt, eq, lt  output  1 each  registered result, one-hot after first completion.

Function
REQ-012 States: IDLE, CMP; reset state IDLE.
REQ-013 IDLE, start=1: latch a, b, signed_mode; idx := NS-1; go CMP; busy=1 from next cycle.
REQ-014 IDLE, start=0: hold; gt/eq/lt keep last result.
REQ-015 Signed mode: MSB of latched a and b inverted before comparison (sign flip); no other operand change.
REQ-016 CMP, en=1: compare slice idx (bits idx*SLICE+SLICE-1 .. idx*SLICE) of latched operands, MSB-first.
REQ-017 Slices unequal: gt/lt set from that slice, eq=0, done=1 next cycle, return IDLE (early exit).
REQ-018 Slices equal, idx>0: idx := idx-1, stay CMP.
REQ-019 Slices equal, idx=0: eq=1, gt=lt=0, done=1 next cycle, return IDLE.
REQ-020 CMP, en=0: idx, latched operands, outputs frozen; no done.
REQ-021 Latency: k rising edges after the start-accept edge, k = slices examined (1..NS), plus en=0 cycles; done and busy=0 appear in the same cycle.
REQ-022 start while busy=1: ignored, no effect on latched operands or result.
REQ-023 start in the cycle done=1 (busy=0): accepted; back-to-back comparisons allowed.
REQ-024 gt, eq, lt SHALL never be simultaneously 1; exactly one set after any completion.
REQ-025 a, b changes after the accept edge SHALL NOT affect the running comparison.

Reset
REQ-026 rst=1: state IDLE, idx=0, busy=0, done=0, gt=0, eq=0, lt=0, latched operands 0.
REQ-027 rst SHALL override start and en, including mid-comparison; aborted comparison produces no done.
REQ-028 First start after rst released SHALL be accepted normally.

Structure
REQ-029 Shared package holds: state enum (IDLE, CMP), result encoding constants (GT, EQ, LT), WIDTH/SLICE defaults.
REQ-030 One sub-module slice_cmp: combinational SLICE-bit magnitude compare, outputs gt/eq/lt; instantiated once, fed via idx mux.
REQ-031 Parameter legality (WIDTH mod SLICE = 0) SHALL be checked at elaboration.

Verification (WIDTH=16, SLICE=4)
REQ-032 a=0x8000, b=0x7FFF, unsigned -> gt=1 with done 1 cycle after accept; signed -> lt=1, 1 cycle.
REQ-033 a=b=0x1234, both modes -> eq=1, done 4 cycles after accept.
REQ-034 a=0x1235, b=0x1234 -> gt=1 after 4 cycles; a=0x1234, b=0x1334 -> lt=1 after 2 cycles.
REQ-035 a=0xFFFF, b=0x0001 signed, en=0 for 3 cycles after accept -> lt=1, done 4 cycles after accept; start pulses while busy ignored.
REQ-036 rst asserted 2 cycles into a=b=0xAAAA compare -> all outputs 0, no done; next start a=0x0001, b=0x0000 -> gt=1 after 4 cycles.
REQ-037 Back-to-back: start held high across done -> second comparison accepted in done cycle, results correct for both.
